// File: rtl/i2c_config_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_config_sequencer
//
// Walks an external configuration table and hands one write per entry to an
// I2C master controller. Each entry is framed as {SLAVE_ADDR, sub-address,
// data}. The controller is pulsed through a LOAD/ARM/XFER handshake. Its END
// and ACK flags decide success, retry or final failure. A failed entry never
// stalls the walk: it is counted, flagged and skipped.
//
// Optional feature macro: I2C_CFG_RETRY_EN
//   defined   : a failed entry is re-attempted up to MAX_RETRY times before
//               it is counted as a final failure.
//   undefined : every failure is final on the first attempt.
//
// Parameters
//   SLAVE_ADDR   : 8-bit device write address placed on I2C_DATA[31:24]
//   LUT_SIZE     : number of table entries (1..64)
//   PWR_DELAY    : iCLK cycles to wait after reset release
//   XFER_TIMEOUT : XFER cycles allowed before an attempt is declared failed
//   MAX_RETRY    : re-attempts per entry (retry build only)
//
// Ports
//   iCLK       in   1  clock shared with the I2C controller
//   RST        in   1  asynchronous reset, active low
//   START      in   1  restart pulse, honoured only when the sequence is done
//   LUT_INDEX  out  6  current table entry
//   LUT_DATA   in  24  {sub-address, data} for LUT_INDEX, same cycle
//   I2C_DATA   out 32  {SLAVE_ADDR, LUT_DATA} latched for the controller
//   GO         out  1  transfer enable, high only while transferring
//   W_R        out  1  always 0 (write)
//   END        in   1  controller end flag (low while a transfer runs)
//   ACK        in   1  controller NACK summary (1 = at least one NACK)
//   BUSY       out  1  sequence active
//   DONE       out  1  all entries processed
//   ERROR      out  1  at least one entry finally failed
//   FAIL_COUNT out  6  finally failed entries, saturating at 63
// ---------------------------------------------------------------------------
module i2c_config_sequencer #(
  parameter logic [7:0] SLAVE_ADDR   = 8'h34,
  parameter int         LUT_SIZE     = 16,
  parameter int         PWR_DELAY    = 1000,
  parameter int         XFER_TIMEOUT = 63,
  parameter int         MAX_RETRY    = 3
) (
  input  logic        iCLK,
  input  logic        RST,
  input  logic        START,
  output logic [5:0]  LUT_INDEX,
  input  logic [23:0] LUT_DATA,
  output logic [31:0] I2C_DATA,
  output logic        GO,
  output logic        W_R,
  input  logic        END,
  input  logic        ACK,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [5:0]  FAIL_COUNT
);

  localparam int DELAY_W = (PWR_DELAY > 1) ? $clog2(PWR_DELAY) : 1;
  localparam logic [DELAY_W-1:0] DELAY_LAST =
    DELAY_W'((PWR_DELAY > 0) ? PWR_DELAY - 1 : 0);

  localparam int TIMER_W = (XFER_TIMEOUT > 1) ? $clog2(XFER_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST =
    TIMER_W'((XFER_TIMEOUT > 0) ? XFER_TIMEOUT - 1 : 0);

  localparam logic [5:0] LAST_INDEX = 6'(LUT_SIZE - 1);

`ifdef I2C_CFG_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
`endif

  typedef enum logic [2:0] {
    S_DELAY,
    S_LOAD,
    S_ARM,
    S_XFER,
    S_CHECK,
    S_NEXT,
    S_DONE
  } stateT;

  stateT               r_state;
  stateT               w_nextState;
  logic [DELAY_W-1:0]  r_delayCnt;
  logic [TIMER_W-1:0]  r_timer;
  logic                r_endLow;
  logic [31:0]         r_i2cData;
  logic [5:0]          r_lutIndex;
  logic                r_error;
  logic [5:0]          r_failCount;
  logic                w_attemptFail;
  logic                w_finalFail;
`ifdef I2C_CFG_RETRY_EN
  logic [RETRY_W-1:0]  r_retry;
  logic                w_retryNow;
`endif

  // Next-state decode. An attempt fails either on a NACK in CHECK or when the
  // XFER timer expires before a genuine END low-then-high has been seen.
  // Completion wins over timeout when both happen in the same cycle. The
  // failure routing (retry or skip) is applied after the per-state decode so
  // both failure sources share one path.
  always_comb begin
    w_nextState   = r_state;
    w_attemptFail = 1'b0;
    w_finalFail   = 1'b0;
`ifdef I2C_CFG_RETRY_EN
    w_retryNow    = 1'b0;
`endif
    case (r_state)
      S_DELAY: begin
        if (r_delayCnt == DELAY_LAST) begin
          w_nextState = S_LOAD;
        end
      end
      S_LOAD: begin
        w_nextState = S_ARM;
      end
      S_ARM: begin
        w_nextState = S_XFER;
      end
      S_XFER: begin
        if (END && r_endLow) begin
          w_nextState = S_CHECK;
        end else if (r_timer == TIMEOUT_LAST) begin
          w_attemptFail = 1'b1;
        end
      end
      S_CHECK: begin
        if (!ACK) begin
          w_nextState = S_NEXT;
        end else begin
          w_attemptFail = 1'b1;
        end
      end
      S_NEXT: begin
        if (r_lutIndex == LAST_INDEX) begin
          w_nextState = S_DONE;
        end else begin
          w_nextState = S_LOAD;
        end
      end
      S_DONE: begin
        if (START) begin
          w_nextState = S_LOAD;
        end
      end
      default: begin
        w_nextState = S_DELAY;
      end
    endcase

    if (w_attemptFail) begin
`ifdef I2C_CFG_RETRY_EN
      if (r_retry < RETRY_LIMIT) begin
        w_retryNow  = 1'b1;
        w_nextState = S_LOAD;
      end else begin
        w_finalFail = 1'b1;
        w_nextState = S_NEXT;
      end
`else
      w_finalFail = 1'b1;
      w_nextState = S_NEXT;
`endif
    end
  end

  // State register. Reset lands in DELAY, which also pulls GO low at once
  // because GO is decoded straight from the state.
  always_ff @(posedge iCLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_DELAY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Power-up delay counter. It only runs in DELAY, which is entered solely
  // from reset, so a restart via START never repeats the wait.
  always_ff @(posedge iCLK or negedge RST) begin
    if (!RST) begin
      r_delayCnt <= '0;
    end else if (r_state == S_DELAY && r_delayCnt != DELAY_LAST) begin
      r_delayCnt <= r_delayCnt + 1'b1;
    end
  end

  // Transfer timer and the END-seen-low flag. The flag guards against a
  // controller whose END is still high from the previous transfer: only a
  // low-then-high sequence observed from ARM onward counts as completion.
  always_ff @(posedge iCLK or negedge RST) begin
    if (!RST) begin
      r_timer  <= '0;
      r_endLow <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_timer  <= '0;
          r_endLow <= 1'b0;
        end
        S_ARM: begin
          if (!END) begin
            r_endLow <= 1'b1;
          end
        end
        S_XFER: begin
          r_timer <= r_timer + 1'b1;
          if (!END) begin
            r_endLow <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Transfer word. Latched once per attempt in LOAD and held until the next
  // LOAD so the controller sees a stable word for the whole transfer.
  always_ff @(posedge iCLK or negedge RST) begin
    if (!RST) begin
      r_i2cData <= '0;
    end else if (r_state == S_LOAD) begin
      r_i2cData <= {SLAVE_ADDR, LUT_DATA};
    end
  end

  // Table index and failure bookkeeping. START in DONE rewinds the walk and
  // clears the error summary. A final failure is sticky until then.
  always_ff @(posedge iCLK or negedge RST) begin
    if (!RST) begin
      r_lutIndex  <= '0;
      r_error     <= 1'b0;
      r_failCount <= '0;
    end else begin
      if (r_state == S_DONE && START) begin
        r_lutIndex  <= '0;
        r_error     <= 1'b0;
        r_failCount <= '0;
      end else begin
        if (r_state == S_NEXT && r_lutIndex != LAST_INDEX) begin
          r_lutIndex <= r_lutIndex + 6'd1;
        end
        if (w_finalFail) begin
          r_error <= 1'b1;
          if (r_failCount != 6'h3F) begin
            r_failCount <= r_failCount + 6'd1;
          end
        end
      end
    end
  end

`ifdef I2C_CFG_RETRY_EN
  // Per-entry retry counter. NEXT always lasts one cycle, so clearing there
  // gives every entry a fresh set of attempts.
  always_ff @(posedge iCLK or negedge RST) begin
    if (!RST) begin
      r_retry <= '0;
    end else if (r_state == S_NEXT) begin
      r_retry <= '0;
    end else if (w_retryNow) begin
      r_retry <= r_retry + 1'b1;
    end
  end
`endif

  // Output decode. Status flags come straight from the state so they track
  // reset asynchronously.
  always_comb begin
    GO         = (r_state == S_XFER);
    BUSY       = (r_state != S_DONE);
    DONE       = (r_state == S_DONE);
    W_R        = 1'b0;
    LUT_INDEX  = r_lutIndex;
    I2C_DATA   = r_i2cData;
    ERROR      = r_error;
    FAIL_COUNT = r_failCount;
  end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_config_sequencer
//
// Drives i2c_config_sequencer with a 4-entry table and a short power-up delay
// against a small behavioural I2C controller. The controller can ACK
// everything, NACK entry 1 persistently, NACK entry 2 once, or hold END high
// so every attempt times out. Expected results come from a vector table plus
// hand-written restart and reset sequences. Works with or without
// I2C_CFG_RETRY_EN defined.
// ---------------------------------------------------------------------------
module tb_i2c_config_sequencer;

  localparam int LUT_SIZE     = 4;
  localparam int PWR_DELAY    = 10;
  localparam int XFER_TIMEOUT = 63;
  localparam int MAX_RETRY    = 3;
`ifdef I2C_CFG_RETRY_EN
  localparam int RETRIES = MAX_RETRY;
`else
  localparam int RETRIES = 0;
`endif
  localparam int BUDGET      = 6000;
  localparam int FIRST_GO    = PWR_DELAY + 2;
  localparam int NORMAL_LEN  = 9;
  localparam int ONCE2_ERR   = (RETRIES > 0) ? 0 : 1;
  localparam int ONCE2_ATT2  = (RETRIES > 0) ? 2 : 1;

  typedef enum int {MODE_ACK, MODE_NACK1, MODE_ONCE2, MODE_HOLD} modeT;

  typedef struct {
    string            name;
    modeT             mode;
    logic [3:0][7:0]  expAttempts;
    int               expError;
    int               expFail;
    int               expGoLen;
  } vectorT;

  logic        iCLK = 1'b0;
  logic        RST;
  logic        START;
  logic [5:0]  LUT_INDEX;
  logic [23:0] LUT_DATA;
  logic [31:0] I2C_DATA;
  logic        GO;
  logic        W_R;
  logic        END = 1'b1;
  logic        ACK = 1'b0;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic [5:0]  FAIL_COUNT;

  int   nCompared   = 0;
  int   nMismatched = 0;
  int   attempts [4];
  int   goLen       = 0;
  int   lastGoLen   = 0;
  int   firstRise   = -1;
  int   cycleCount  = 0;
  int   releaseCycle = 0;
  int   dataErrors  = 0;
  logic prevGo      = 1'b0;
  logic [31:0] heldWord = '0;
  modeT mode        = MODE_ACK;
  vectorT vectors [4];

  i2c_config_sequencer #(
    .SLAVE_ADDR   (8'h34),
    .LUT_SIZE     (LUT_SIZE),
    .PWR_DELAY    (PWR_DELAY),
    .XFER_TIMEOUT (XFER_TIMEOUT),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .iCLK       (iCLK),
    .RST        (RST),
    .START      (START),
    .LUT_INDEX  (LUT_INDEX),
    .LUT_DATA   (LUT_DATA),
    .I2C_DATA   (I2C_DATA),
    .GO         (GO),
    .W_R        (W_R),
    .END        (END),
    .ACK        (ACK),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERROR      (ERROR),
    .FAIL_COUNT (FAIL_COUNT)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 iCLK = ~iCLK;

  // Cycle counter used to time the first GO rise after reset release.
  always @(posedge iCLK) cycleCount++;

  // Table contents: distinct sub-address and data per entry.
  function automatic logic [23:0] lutWord(input logic [5:0] idx);
    logic [7:0]  sub;
    logic [15:0] dat;
    sub = 8'h10 + {2'b00, idx};
    dat = 16'hC0DE ^ {10'd0, idx};
    return {sub, dat};
  endfunction

  assign LUT_DATA = lutWord(LUT_INDEX);

  // Behavioural controller, evaluated on the falling edge. While GO is high
  // END is low for 8 cycles and then high again (unless held high). ACK
  // reflects the NACK scenario for the current entry. Each GO rise logs an
  // attempt and checks the presented word. The word must also stay constant
  // while GO is high.
  always @(negedge iCLK) begin
    if (GO && !prevGo) begin
      if (LUT_INDEX < 6'd4) begin
        attempts[int'(LUT_INDEX)]++;
      end
      if (I2C_DATA !== {8'h34, lutWord(LUT_INDEX)}) begin
        dataErrors++;
      end
      heldWord = I2C_DATA;
      if (firstRise < 0) begin
        firstRise = cycleCount - releaseCycle;
      end
    end else if (GO && I2C_DATA !== heldWord) begin
      dataErrors++;
    end
    if (GO) begin
      goLen++;
      END = (mode == MODE_HOLD) ? 1'b1 : !(goLen >= 1 && goLen <= 8);
    end else begin
      if (prevGo) begin
        lastGoLen = goLen;
      end
      goLen = 0;
      END   = 1'b1;
    end
    ACK = (mode == MODE_NACK1 && LUT_INDEX == 6'd1) ||
          (mode == MODE_ONCE2 && LUT_INDEX == 6'd2 && attempts[2] == 1);
    prevGo = GO;
  end

  function automatic vectorT mkVec(input string n, input modeT m,
                                   input int a0, input int a1, input int a2,
                                   input int a3, input int e, input int f,
                                   input int gl);
    vectorT v;
    v.name        = n;
    v.mode        = m;
    v.expAttempts = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    v.expError    = e;
    v.expFail     = f;
    v.expGoLen    = gl;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic clearLog();
    for (int i = 0; i < 4; i++) begin
      attempts[i] = 0;
    end
    dataErrors = 0;
    firstRise  = -1;
    lastGoLen  = 0;
  endtask

  // Hold reset for two cycles with the controller in the given mode, then
  // release it on a falling edge.
  task automatic applyStimulus(input modeT m);
    @(negedge iCLK);
    RST   = 1'b0;
    START = 1'b0;
    mode  = m;
    clearLog();
    @(negedge iCLK);
    @(negedge iCLK);
    releaseCycle = cycleCount;
    RST = 1'b1;
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (DONE !== 1'b1 && n < BUDGET) begin
      @(negedge iCLK);
      n++;
    end
    checkOutput({tag, "_doneReached"}, 32'(DONE === 1'b1), 32'd1);
  endtask

  task automatic checkAttempts(input string tag, input logic [3:0][7:0] exp);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s_attempts%0d", tag, i), 32'(attempts[i]),
                  32'(exp[i]));
    end
  endtask

  initial begin
    int n;
    RST   = 1'b0;
    START = 1'b0;
    for (int i = 0; i < 4; i++) begin
      attempts[i] = 0;
    end

    vectors[0] = mkVec("allAck",   MODE_ACK,   1, 1, 1, 1, 0, 0, NORMAL_LEN);
    vectors[1] = mkVec("nackE1",   MODE_NACK1, 1, RETRIES + 1, 1, 1, 1, 1,
                       NORMAL_LEN);
    vectors[2] = mkVec("onceE2",   MODE_ONCE2, 1, 1, ONCE2_ATT2, 1,
                       ONCE2_ERR, ONCE2_ERR, NORMAL_LEN);
    vectors[3] = mkVec("holdEnd",  MODE_HOLD,  RETRIES + 1, RETRIES + 1,
                       RETRIES + 1, RETRIES + 1, 1, 4, XFER_TIMEOUT);

    // Values while reset is held.
    #3;
    checkOutput("rst_GO",        32'(GO),         32'd0);
    checkOutput("rst_W_R",       32'(W_R),        32'd0);
    checkOutput("rst_BUSY",      32'(BUSY),       32'd1);
    checkOutput("rst_DONE",      32'(DONE),       32'd0);
    checkOutput("rst_ERROR",     32'(ERROR),      32'd0);
    checkOutput("rst_FAILCOUNT", 32'(FAIL_COUNT), 32'd0);
    checkOutput("rst_LUTINDEX",  32'(LUT_INDEX),  32'd0);
    checkOutput("rst_I2CDATA",   I2C_DATA,        32'd0);

    // Table-driven full-sequence scenarios.
    for (int v = 0; v < 4; v++) begin
      $display("[TB] scenario %s", vectors[v].name);
      applyStimulus(vectors[v].mode);
      waitDone(vectors[v].name);
      checkOutput({vectors[v].name, "_BUSY"},  32'(BUSY), 32'd0);
      checkOutput({vectors[v].name, "_GO"},    32'(GO),   32'd0);
      checkOutput({vectors[v].name, "_ERROR"}, 32'(ERROR),
                  32'(vectors[v].expError));
      checkOutput({vectors[v].name, "_FAILCOUNT"}, 32'(FAIL_COUNT),
                  32'(vectors[v].expFail));
      checkOutput({vectors[v].name, "_firstGo"}, 32'(firstRise),
                  32'(FIRST_GO));
      checkOutput({vectors[v].name, "_goLen"}, 32'(lastGoLen),
                  32'(vectors[v].expGoLen));
      checkOutput({vectors[v].name, "_dataErrors"}, 32'(dataErrors), 32'd0);
      checkAttempts(vectors[v].name, vectors[v].expAttempts);
    end

    // START in DONE: restart straight into LOAD, no power-up delay, with the
    // error summary from the timeout scenario cleared.
    mode = MODE_ACK;
    clearLog();
    @(negedge iCLK);
    START = 1'b1;
    @(negedge iCLK);
    START = 1'b0;
    checkOutput("restart_BUSY",      32'(BUSY),       32'd1);
    checkOutput("restart_DONE",      32'(DONE),       32'd0);
    checkOutput("restart_ERROR",     32'(ERROR),      32'd0);
    checkOutput("restart_FAILCOUNT", 32'(FAIL_COUNT), 32'd0);
    checkOutput("restart_LUTINDEX",  32'(LUT_INDEX),  32'd0);
    checkOutput("restart_GOload",    32'(GO),         32'd0);
    @(negedge iCLK);
    checkOutput("restart_GOarm",     32'(GO),         32'd0);
    @(negedge iCLK);
    checkOutput("restart_GOxfer",    32'(GO),         32'd1);
    waitDone("restart");
    checkOutput("restart_ERRORend",  32'(ERROR),      32'd0);
    checkAttempts("restart", {8'd1, 8'd1, 8'd1, 8'd1});

    // START while busy: once during the power-up delay, once mid-transfer.
    applyStimulus(MODE_ACK);
    repeat (3) @(negedge iCLK);
    START = 1'b1;
    @(negedge iCLK);
    START = 1'b0;
    n = 0;
    while (GO !== 1'b1 && n < BUDGET) begin
      @(negedge iCLK);
      n++;
    end
    checkOutput("busyStart_goSeen", 32'(GO === 1'b1), 32'd1);
    START = 1'b1;
    @(negedge iCLK);
    START = 1'b0;
    checkOutput("busyStart_GO",       32'(GO),        32'd1);
    checkOutput("busyStart_LUTINDEX", 32'(LUT_INDEX), 32'd0);
    waitDone("busyStart");
    checkOutput("busyStart_firstGo", 32'(firstRise), 32'(FIRST_GO));
    checkAttempts("busyStart", {8'd1, 8'd1, 8'd1, 8'd1});

    // Reset asserted during the transfer of entry 1.
    applyStimulus(MODE_ACK);
    n = 0;
    while (!(GO === 1'b1 && LUT_INDEX == 6'd1) && n < BUDGET) begin
      @(negedge iCLK);
      n++;
    end
    checkOutput("midRst_entry1Seen",
                32'(GO === 1'b1 && LUT_INDEX == 6'd1), 32'd1);
    RST = 1'b0;
    #1;
    checkOutput("midRst_GO",       32'(GO),        32'd0);
    checkOutput("midRst_LUTINDEX", 32'(LUT_INDEX), 32'd0);
    checkOutput("midRst_BUSY",     32'(BUSY),      32'd1);
    clearLog();
    @(negedge iCLK);
    releaseCycle = cycleCount;
    RST = 1'b1;
    waitDone("midRst");
    checkOutput("midRst_firstGo",    32'(firstRise),  32'(FIRST_GO));
    checkOutput("midRst_dataErrors", 32'(dataErrors), 32'd0);
    checkAttempts("midRst", {8'd1, 8'd1, 8'd1, 8'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/i2c_config_sequencer.md
I2C_CONFIG_SEQUENCER -- requirements
Module: i2c_config_sequencer

Interface
REQ-001 Parameter SLAVE_ADDR, 8'h34, device write address driven on I2C_DATA[31:24].
REQ-002 Parameter LUT_SIZE, 16, number of configuration entries; legal range 1..64.
REQ-003 Parameter PWR_DELAY, 1000, iCLK cycles to wait after reset release before the first transfer.
REQ-004 Parameter XFER_TIMEOUT, 63, maximum XFER cycles before a transfer is declared failed.
REQ-005 Parameter MAX_RETRY, 3, re-attempts per entry after a failure (retry build only).
REQ-006 iCLK  in  1  clock; the same clock that drives the I2C controller.
REQ-007 RST  in  1  reset, asynchronous, active-low.
REQ-008 START  in  1  single-cycle pulse that restarts the sequence; honoured only in DONE.
REQ-009 LUT_INDEX  out  6  current entry index into the external configuration table.
REQ-010 LUT_DATA  in  24  {sub-address[23:16], data[15:0]}; combinational from LUT_INDEX, valid in the same cycle.
REQ-011 I2C_DATA  out  32  {SLAVE_ADDR, LUT_DATA} presented to the controller.
REQ-012 GO  out  1  transfer enable to the controller; held high for the whole transfer.
REQ-013 W_R  out  1  constant 0 (write).
REQ-014 END  in  1  controller end flag; drops low at transfer start and rises when the stop condition completes.
REQ-015 ACK  in  1  controller acknowledge summary; 1 = at least one NACK.
REQ-016 BUSY / DONE / ERROR  out  1 each  sequence active / all entries processed / any entry finally failed.
REQ-017 FAIL_COUNT  out  6  number of finally failed entries; saturates at 63.

Function
REQ-018 FSM states: DELAY, LOAD, ARM, XFER, CHECK, NEXT, DONE.
REQ-019 DELAY: count PWR_DELAY cycles, then go to LOAD.
REQ-020 LOAD: register I2C_DATA <= {SLAVE_ADDR, LUT_DATA}, drive GO=0, clear the timer and the end_low flag, then go to ARM.
REQ-021 ARM: keep GO=0 for exactly one more cycle so the controller counter parks at 0, then go to XFER.
REQ-022 XFER: drive GO=1 and increment the timer.
REQ-023 end_low: set when END is sampled 0 in ARM or XFER.
REQ-024 XFER exit: END=1 with end_low set goes to CHECK; the timer reaching XFER_TIMEOUT first is a failure.
REQ-025 END=1 without end_low set never completes a transfer.
REQ-026 CHECK: ACK=0 is success and goes to NEXT; ACK=1 is a failure.
REQ-027 NEXT: at LUT_INDEX == LUT_SIZE-1 go to DONE; otherwise increment LUT_INDEX and go to LOAD.
REQ-028 NEXT: clear the per-entry retry count on leaving.
REQ-029 DONE: GO=0, DONE=1, BUSY=0.
REQ-030 START in DONE: clear LUT_INDEX, ERROR and FAIL_COUNT, then go to LOAD; the power-up delay is not repeated.
REQ-031 START in any other state is ignored.
REQ-032 GO is 0 in every state except XFER.
REQ-033 I2C_DATA stays stable from LOAD until the next LOAD.
REQ-034 BUSY=1 in all states except DONE.
REQ-035 Final failure: set ERROR=1 (sticky until START or reset), increment FAIL_COUNT (saturating), and go to NEXT; the sequence never stalls.
REQ-036 Nominal successful entry time: LOAD 1 + ARM 1 + XFER about 42 + CHECK 1 + NEXT 1 cycles.

Reset
REQ-037 Reset values: I2C_DATA=0, GO=0, W_R=0, LUT_INDEX=0, BUSY=1, DONE=0, ERROR=0, FAIL_COUNT=0, retry=0, timer=0, state=DELAY.
REQ-038 RST asserted mid-transfer forces GO=0 asynchronously; after release, the full sequence reruns from DELAY.

Configuration
REQ-039 Macro I2C_CFG_RETRY_EN defined: on a failure with retry < MAX_RETRY, increment retry and return to LOAD with the same index; when retry = MAX_RETRY, apply REQ-035.
REQ-040 Macro I2C_CFG_RETRY_EN undefined: every failure applies REQ-035 immediately; the retry counter and MAX_RETRY logic are absent.

Verification
REQ-041 LUT_SIZE=4, PWR_DELAY=10, controller model always ACK=0 -> four GO pulses with I2C_DATA=34_xxxxxx per entry; first GO rise at or after 12 cycles from reset release; DONE=1, ERROR=0, FAIL_COUNT=0.
REQ-042 Retry build, single NACK on entry 2 -> entry 2 transferred twice with identical I2C_DATA; ERROR=0, DONE=1.
REQ-043 Persistent NACK on entry 1, MAX_RETRY=3 -> 4 attempts (1 without the macro); ERROR=1, FAIL_COUNT=1; entries 2-3 still sent; DONE=1.
REQ-044 Controller model holds END=1 -> each attempt times out after 63 XFER cycles and counts as a failure; all entries failed gives FAIL_COUNT=4.
REQ-045 START pulse in DONE -> LOAD next cycle with no delay and ERROR, FAIL_COUNT cleared; START while BUSY=1 -> no effect.
REQ-046 RST low during entry 1 XFER -> GO=0 and LUT_INDEX=0 immediately; after release, PWR_DELAY is honoured and all entries are resent.
